io_input_capture: RTL

Device-side front end for the CPU's memory-mapped input path.
- Synchronises and debounces the two "enter" buttons and latches the 8-bit switch bank into the A and B value registers on each debounced press.
- Exposes these registers, the 3-bit test selector and a status word to the CPU load path, with read-to-clear valid/overflow flags.
- Sits between the board pins and the load-result mux of the IO module.

---
 rtl/io_input_capture.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/io_input_capture.sv
// CPU memory-mapped input front end: synchronises and debounces the enter buttons,
// captures the switch bank into A/B registers and serves them with read-to-clear flags.
`ifndef IO_A_ADDR
`define IO_A_ADDR      32'hFFFF_FC70
`endif
`ifndef IO_B_ADDR
`define IO_B_ADDR      32'hFFFF_FC74
`endif
`ifndef IO_TEST_ADDR
`define IO_TEST_ADDR   32'hFFFF_FC78
`endif
`ifndef IO_STATUS_ADDR
`define IO_STATUS_ADDR 32'hFFFF_FC7C
`endif

module io_input_capture_db #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clock,
    input  logic rst_n,
    input  logic btn,
    output logic pressed
);
    typedef enum logic [2:0] {IDLE, WAIT_PRESS, PRESSED, HELD, WAIT_RELEASE} state_t;

    // The entry cycle counts as the first stable sample, so the count ends one short.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pressed  = 1'b0;
        case (state)
            IDLE: if (btn) begin
                state_nx = WAIT_PRESS;
                cnt_nx   = '0;
            end
            WAIT_PRESS: begin
                if (!btn)                 state_nx = IDLE;
                else if (cnt == CNT_LAST) state_nx = PRESSED;
                else                      cnt_nx   = cnt + CNT_W'(1);
            end
            PRESSED: begin
                pressed  = 1'b1;
                state_nx = HELD;
            end
            HELD: if (!btn) begin
                state_nx = WAIT_RELEASE;
                cnt_nx   = '0;
            end
            WAIT_RELEASE: begin
                if (btn)                  state_nx = HELD;
                else if (cnt == CNT_LAST) state_nx = IDLE;
                else                      cnt_nx   = cnt + CNT_W'(1);
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

module io_input_capture #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic [7:0]  sw_in,
    input  logic        btn_a,
    input  logic        btn_b,
    input  logic [2:0]  test_sw,
    input  logic        rd_en,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    output logic [7:0]  a_val,
    output logic [7:0]  b_val
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0]        btn_s1, btn_s2, pressed, valid, ovf, rd_clr;
    logic [7:0]                  sw_s1, sw_s2;
    logic [2:0]                  test_s1, test_s2;
    logic [NUM_LANES-1:0][7:0]   val;
    logic                        hit_a, hit_b, hit_t, hit_s;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1  <= '0;
            btn_s2  <= '0;
            sw_s1   <= '0;
            sw_s2   <= '0;
            test_s1 <= '0;
            test_s2 <= '0;
        end else begin
            btn_s1  <= {btn_b, btn_a};
            btn_s2  <= btn_s1;
            sw_s1   <= sw_in;
            sw_s2   <= sw_s1;
            test_s1 <= test_sw;
            test_s2 <= test_s1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            io_input_capture_db #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_db (
                .clock   (clock),
                .rst_n   (rst_n),
                .btn     (btn_s2[g]),
                .pressed (pressed[g])
            );
        end
    endgenerate

    assign hit_a  = rd_en && (rd_addr == `IO_A_ADDR);
    assign hit_b  = rd_en && (rd_addr == `IO_B_ADDR);
    assign hit_t  = rd_en && (rd_addr == `IO_TEST_ADDR);
    assign hit_s  = rd_en && (rd_addr == `IO_STATUS_ADDR);
    assign rd_clr = {hit_b, hit_a};

    // A capture beats a same-cycle read-clear, and a read that consumes the old
    // value means the new capture is not an overflow.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            val   <= '0;
            valid <= '0;
            ovf   <= '0;
        end else begin
            valid <= pressed | (valid & ~rd_clr);
            ovf   <= (pressed & valid & ~rd_clr) | (ovf & ~{NUM_LANES{hit_s}});
            for (int i = 0; i < NUM_LANES; i++)
                if (pressed[i]) val[i] <= sw_s2;
        end
    end

    always_comb begin
        rd_data = '0;
        if (hit_a)      rd_data = {24'b0, val[0]};
        else if (hit_b) rd_data = {24'b0, val[1]};
        else if (hit_t) rd_data = {29'b0, test_s2};
        else if (hit_s) rd_data = {28'b0, ovf, valid};
    end

    assign rd_hit = hit_a | hit_b | hit_t | hit_s;
    assign a_val  = val[0];
    assign b_val  = val[1];
endmodule
